alu_rs: RTL and testbench
=========================

// Module: alu_rs
// PURPOSE
//  Reservation station feeding the integer ALU. It holds dispatched ALU ops until both operands are ready.
//  It snoops the CDB (ALU and LSB results) for pending tags, then issues one ready entry per cycle.
//  Issue outputs drive the ALU op/rs1/rs2/imm/pc inputs plus the ROB tag of the destination.
//  Sits between the dispatcher (upstream) and the ALU (downstream).
// PARAMETERS
//  RS_SIZE    8   number of entries (power of 2, >=2)
//  TAG_W      4   ROB tag width (`ROB_TAG_WIDTH)
//  OP_W       6   inside-opcode width (`INSIDE_OPCODE_WIDTH)
// PORTS
//  clk             in   1      clock, all state on posedge
//  rst             in   1      synchronous reset, ACTIVE-LOW (rst==0 resets)
//  rdy             in   1      global enable; 0 freezes all state
//  in_clear        in   1      ROB misprediction flush
//  in_dsp_valid    in   1      dispatch request this cycle
//  in_dsp_op       in   OP_W   inside opcode
//  in_dsp_vj/vk    in   32     operand values (valid when matching q_vld==0)
//  in_dsp_qj/qk    in   TAG_W  producer ROB tags
//  in_dsp_qj_vld/qk_vld in 1   1 = operand pending on tag
//  in_dsp_imm/pc   in   32     immediate, instruction pc
//  in_dsp_tag      in   TAG_W  destination ROB tag
//  in_cdb_alu_vld/in_cdb_lsb_vld  in 1     CDB result valid (ALU / LSB)
//  in_cdb_alu_tag/in_cdb_lsb_tag  in TAG_W CDB result tags
//  in_cdb_alu_val/in_cdb_lsb_val  in 32    CDB result values
//  out_full        out  1      all RS_SIZE entries busy (combinational)
//  out_alu_valid   out  1      issue valid (registered)
//  out_alu_op      out  OP_W   op to ALU
//  out_alu_rs1/rs2/imm/pc out 32 operands to ALU
//  out_alu_tag     out  TAG_W  destination ROB tag
// BEHAVIOUR
//  - Reset (rst==0 at posedge): all busy bits 0.
//    out_alu_valid=0; out_alu_op/rs1/rs2/imm/pc/tag=0; out_full=0.
//  - Priority per cycle: reset > !rdy (hold all, out_alu_valid forced 0) > in_clear > normal.
//  - in_clear: all busy cleared, next-cycle out_alu_valid=0; a same-cycle dispatch is dropped.
//  - Dispatch: when in_dsp_valid && !out_full, the lowest-index free entry is written.
//    Dispatch while full is ignored (dispatcher violation, no state change).
//  - CDB snoop: every busy entry with qj_vld/qk_vld set and tag == a valid CDB tag copies that value
//    into vj/vk and clears the pending bit. Both CDB buses can hit the same entry in one cycle.
//  - Issue select: lowest-index busy entry with qj_vld==0 && qk_vld==0, evaluated on state at the
//    start of the cycle. Selected fields are registered to out_alu_*, out_alu_valid=1, entry freed.
//    Latency: ready-in-state -> out_alu_valid is 1 cycle. An operand woken by the CDB in cycle N is
//    issuable in N+1. A freshly dispatched entry is never issued in its dispatch cycle.
//  - No ready entry: out_alu_valid=0; out_alu_* data holds its previous value.
//  - Same-cycle dispatch + issue + CDB updates are legal. An entry freed by issue is reusable next cycle.
//  - out_full = (busy count == RS_SIZE); a free slot from an issue appears the cycle after.
//  - Mid-operation reset: entries discarded, outputs return to reset values next edge.
// CONFIGURATION
//  ALU_RS_CDB_BYPASS_EN defined: an incoming dispatch whose qj/qk matches a same-cycle valid CDB tag
//    stores the CDB value with pending bit 0.
//  ALU_RS_CDB_BYPASS_EN undefined: the entry stores the dispatch fields verbatim. The dispatcher must
//    resolve same-cycle CDB hits itself, otherwise the entry waits forever.
// TESTING
//  1 Reset: rst=0 two cycles -> out_alu_valid=0, out_full=0, all out_alu_* = 0.
//  2 ADDI, vj=5, imm=7, no pending, tag=3 -> next cycle valid=1, op=ADDI, rs1=5, imm=7, tag=3; then valid=0.
//  3 ADD, qj=2 pending, vk=1 -> no issue; CDB alu tag 2 val 9 at N -> issue at N+1 with rs1=9, rs2=1.
//  4 Fill 8 entries all pending -> out_full=1; 9th dispatch dropped; CDB wakes entry 0 -> issued;
//    full drops after the issue; lowest index issued first.
//  5 in_clear with 3 busy entries + same-cycle dispatch -> next cycle all empty, valid=0, full=0.
//  6 BYPASS_EN: dispatch qj=5 with CDB lsb tag 5 val 0x10 same cycle -> issue next cycle with rs1=0x10.
//    Without BYPASS_EN: no issue.

Source files
------------

// File: rtl/alu_rs_if.sv
// Dispatch, CDB snoop and ALU issue bundle for the ALU reservation station.
// slave = reservation station side, master = dispatcher/CDB/ALU side.
interface alu_rs_if #(
  parameter int TAG_W = 4,
  parameter int OP_W  = 6
);
  logic              in_dsp_valid;
  logic [OP_W-1:0]   in_dsp_op;
  logic [31:0]       in_dsp_vj;
  logic [31:0]       in_dsp_vk;
  logic [TAG_W-1:0]  in_dsp_qj;
  logic [TAG_W-1:0]  in_dsp_qk;
  logic              in_dsp_qj_vld;
  logic              in_dsp_qk_vld;
  logic [31:0]       in_dsp_imm;
  logic [31:0]       in_dsp_pc;
  logic [TAG_W-1:0]  in_dsp_tag;
  logic              in_cdb_alu_vld;
  logic [TAG_W-1:0]  in_cdb_alu_tag;
  logic [31:0]       in_cdb_alu_val;
  logic              in_cdb_lsb_vld;
  logic [TAG_W-1:0]  in_cdb_lsb_tag;
  logic [31:0]       in_cdb_lsb_val;
  logic              out_full;
  logic              out_alu_valid;
  logic [OP_W-1:0]   out_alu_op;
  logic [31:0]       out_alu_rs1;
  logic [31:0]       out_alu_rs2;
  logic [31:0]       out_alu_imm;
  logic [31:0]       out_alu_pc;
  logic [TAG_W-1:0]  out_alu_tag;

  modport slave (
    input  in_dsp_valid, in_dsp_op, in_dsp_vj, in_dsp_vk, in_dsp_qj, in_dsp_qk,
           in_dsp_qj_vld, in_dsp_qk_vld, in_dsp_imm, in_dsp_pc, in_dsp_tag,
           in_cdb_alu_vld, in_cdb_alu_tag, in_cdb_alu_val,
           in_cdb_lsb_vld, in_cdb_lsb_tag, in_cdb_lsb_val,
    output out_full, out_alu_valid, out_alu_op, out_alu_rs1, out_alu_rs2,
           out_alu_imm, out_alu_pc, out_alu_tag
  );

  modport master (
    output in_dsp_valid, in_dsp_op, in_dsp_vj, in_dsp_vk, in_dsp_qj, in_dsp_qk,
           in_dsp_qj_vld, in_dsp_qk_vld, in_dsp_imm, in_dsp_pc, in_dsp_tag,
           in_cdb_alu_vld, in_cdb_alu_tag, in_cdb_alu_val,
           in_cdb_lsb_vld, in_cdb_lsb_tag, in_cdb_lsb_val,
    input  out_full, out_alu_valid, out_alu_op, out_alu_rs1, out_alu_rs2,
           out_alu_imm, out_alu_pc, out_alu_tag
  );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops, snoops both CDBs, issues the lowest ready entry.
// Define ALU_RS_CDB_BYPASS_EN to capture same-cycle CDB results into a dispatching entry.
module alu_rs #(
  parameter int RS_SIZE = 8,
  parameter int TAG_W   = 4,
  parameter int OP_W    = 6
) (
  input logic      clk,
  input logic      rst,
  input logic      rdy,
  input logic      in_clear,
  alu_rs_if.slave  bus
);
  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] qj_vld;
  logic [RS_SIZE-1:0] qk_vld;
  logic [OP_W-1:0]    op_q  [RS_SIZE];
  logic [31:0]        vj_q  [RS_SIZE];
  logic [31:0]        vk_q  [RS_SIZE];
  logic [31:0]        imm_q [RS_SIZE];
  logic [31:0]        pc_q  [RS_SIZE];
  logic [TAG_W-1:0]   qj_q  [RS_SIZE];
  logic [TAG_W-1:0]   qk_q  [RS_SIZE];
  logic [TAG_W-1:0]   tag_q [RS_SIZE];

  logic [RS_SIZE-1:0] ready_vec;
  logic               full;
  logic               free_found;
  logic               iss_found;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   iss_idx;
  logic [31:0]        dsp_vj;
  logic [31:0]        dsp_vk;
  logic               dsp_qj_vld;
  logic               dsp_qk_vld;
  logic               dsp_accept;

  function automatic logic cdb_hit(input logic vld, input logic [TAG_W-1:0] cdb_tag,
                                   input logic [TAG_W-1:0] q);
    return vld && (cdb_tag == q);
  endfunction

  assign ready_vec    = busy & ~qj_vld & ~qk_vld;
  assign full         = &busy;
  assign bus.out_full = full;
  assign dsp_accept   = bus.in_dsp_valid && !full && free_found;

  // Descending scans so the lowest matching index is the one that sticks.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    iss_found  = 1'b0;
    iss_idx    = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (ready_vec[i]) begin
        iss_found = 1'b1;
        iss_idx   = IDX_W'(i);
      end
    end
  end

`ifdef ALU_RS_CDB_BYPASS_EN
  always_comb begin
    dsp_vj     = bus.in_dsp_vj;
    dsp_vk     = bus.in_dsp_vk;
    dsp_qj_vld = bus.in_dsp_qj_vld;
    dsp_qk_vld = bus.in_dsp_qk_vld;
    if (bus.in_dsp_qj_vld) begin
      if (cdb_hit(bus.in_cdb_alu_vld, bus.in_cdb_alu_tag, bus.in_dsp_qj)) begin
        dsp_vj     = bus.in_cdb_alu_val;
        dsp_qj_vld = 1'b0;
      end else if (cdb_hit(bus.in_cdb_lsb_vld, bus.in_cdb_lsb_tag, bus.in_dsp_qj)) begin
        dsp_vj     = bus.in_cdb_lsb_val;
        dsp_qj_vld = 1'b0;
      end
    end
    if (bus.in_dsp_qk_vld) begin
      if (cdb_hit(bus.in_cdb_alu_vld, bus.in_cdb_alu_tag, bus.in_dsp_qk)) begin
        dsp_vk     = bus.in_cdb_alu_val;
        dsp_qk_vld = 1'b0;
      end else if (cdb_hit(bus.in_cdb_lsb_vld, bus.in_cdb_lsb_tag, bus.in_dsp_qk)) begin
        dsp_vk     = bus.in_cdb_lsb_val;
        dsp_qk_vld = 1'b0;
      end
    end
  end
`else
  // Without bypass the dispatcher owns same-cycle CDB forwarding.
  assign dsp_vj     = bus.in_dsp_vj;
  assign dsp_vk     = bus.in_dsp_vk;
  assign dsp_qj_vld = bus.in_dsp_qj_vld;
  assign dsp_qk_vld = bus.in_dsp_qk_vld;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy              <= '0;
      qj_vld            <= '0;
      qk_vld            <= '0;
      bus.out_alu_valid <= 1'b0;
      bus.out_alu_op    <= '0;
      bus.out_alu_rs1   <= '0;
      bus.out_alu_rs2   <= '0;
      bus.out_alu_imm   <= '0;
      bus.out_alu_pc    <= '0;
      bus.out_alu_tag   <= '0;
    end else if (!rdy) begin
      bus.out_alu_valid <= 1'b0;
    end else if (in_clear) begin
      busy              <= '0;
      bus.out_alu_valid <= 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i] && qj_vld[i]) begin
          if (cdb_hit(bus.in_cdb_alu_vld, bus.in_cdb_alu_tag, qj_q[i])) begin
            vj_q[i]   <= bus.in_cdb_alu_val;
            qj_vld[i] <= 1'b0;
          end else if (cdb_hit(bus.in_cdb_lsb_vld, bus.in_cdb_lsb_tag, qj_q[i])) begin
            vj_q[i]   <= bus.in_cdb_lsb_val;
            qj_vld[i] <= 1'b0;
          end
        end
        if (busy[i] && qk_vld[i]) begin
          if (cdb_hit(bus.in_cdb_alu_vld, bus.in_cdb_alu_tag, qk_q[i])) begin
            vk_q[i]   <= bus.in_cdb_alu_val;
            qk_vld[i] <= 1'b0;
          end else if (cdb_hit(bus.in_cdb_lsb_vld, bus.in_cdb_lsb_tag, qk_q[i])) begin
            vk_q[i]   <= bus.in_cdb_lsb_val;
            qk_vld[i] <= 1'b0;
          end
        end
      end

      if (iss_found) begin
        busy[iss_idx]     <= 1'b0;
        bus.out_alu_valid <= 1'b1;
        bus.out_alu_op    <= op_q[iss_idx];
        bus.out_alu_rs1   <= vj_q[iss_idx];
        bus.out_alu_rs2   <= vk_q[iss_idx];
        bus.out_alu_imm   <= imm_q[iss_idx];
        bus.out_alu_pc    <= pc_q[iss_idx];
        bus.out_alu_tag   <= tag_q[iss_idx];
      end else begin
        bus.out_alu_valid <= 1'b0;
      end

      // The free slot is never the issuing one, so these writes cannot collide.
      if (dsp_accept) begin
        busy[free_idx]   <= 1'b1;
        op_q[free_idx]   <= bus.in_dsp_op;
        vj_q[free_idx]   <= dsp_vj;
        vk_q[free_idx]   <= dsp_vk;
        qj_q[free_idx]   <= bus.in_dsp_qj;
        qk_q[free_idx]   <= bus.in_dsp_qk;
        qj_vld[free_idx] <= dsp_qj_vld;
        qk_vld[free_idx] <= dsp_qk_vld;
        imm_q[free_idx]  <= bus.in_dsp_imm;
        pc_q[free_idx]   <= bus.in_dsp_pc;
        tag_q[free_idx]  <= bus.in_dsp_tag;
      end
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: stimulus pushes expected issues, a negedge monitor pops and compares.
module tb_alu_rs;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b0;
  logic in_clear = 1'b0;
  always #5 clk = ~clk;

  alu_rs_if #(.TAG_W(4), .OP_W(6)) bus ();
  alu_rs #(.RS_SIZE(8), .TAG_W(4), .OP_W(6)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .in_clear(in_clear), .bus(bus)
  );

  localparam logic [5:0] OP_ADD  = 6'd2;
  localparam logic [5:0] OP_SUB  = 6'd3;
  localparam logic [5:0] OP_ADDI = 6'd10;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] rs1, rs2, imm, pc;
    logic [3:0]  tag;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (bus.out_alu_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue cyc=%0d actual tag=%0d rs1=%h required no issue",
                 cyc, bus.out_alu_tag, bus.out_alu_rs1);
      end else begin
        e = sb.pop_front();
        if (bus.out_alu_op !== e.op || bus.out_alu_rs1 !== e.rs1 || bus.out_alu_rs2 !== e.rs2 ||
            bus.out_alu_imm !== e.imm || bus.out_alu_pc !== e.pc || bus.out_alu_tag !== e.tag ||
            cyc != e.cyc) begin
          errors++;
          $display("FAIL issue_tag%0d actual op=%0d rs1=%h rs2=%h imm=%h pc=%h tag=%0d cyc=%0d required op=%0d rs1=%h rs2=%h imm=%h pc=%h tag=%0d cyc=%0d",
                   e.tag, bus.out_alu_op, bus.out_alu_rs1, bus.out_alu_rs2, bus.out_alu_imm,
                   bus.out_alu_pc, bus.out_alu_tag, cyc, e.op, e.rs1, e.rs2, e.imm, e.pc, e.tag, e.cyc);
        end
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_issue tag=%0d actual valid=0 required valid=1 at cyc=%0d",
               sb[0].tag, sb[0].cyc);
      void'(sb.pop_front());
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.in_dsp_valid   = 1'b0;
    bus.in_cdb_alu_vld = 1'b0;
    bus.in_cdb_lsb_vld = 1'b0;
    in_clear           = 1'b0;
  endtask

  task automatic dsp(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                     input logic qjv, input logic [3:0] qj, input logic qkv, input logic [3:0] qk,
                     input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag);
    bus.in_dsp_valid  = 1'b1;
    bus.in_dsp_op     = op;
    bus.in_dsp_vj     = vj;
    bus.in_dsp_vk     = vk;
    bus.in_dsp_qj_vld = qjv;
    bus.in_dsp_qj     = qj;
    bus.in_dsp_qk_vld = qkv;
    bus.in_dsp_qk     = qk;
    bus.in_dsp_imm    = imm;
    bus.in_dsp_pc     = pc;
    bus.in_dsp_tag    = tag;
  endtask

  task automatic cdb_alu(input logic [3:0] tag, input logic [31:0] val);
    bus.in_cdb_alu_vld = 1'b1;
    bus.in_cdb_alu_tag = tag;
    bus.in_cdb_alu_val = val;
  endtask

  task automatic cdb_lsb(input logic [3:0] tag, input logic [31:0] val);
    bus.in_cdb_lsb_vld = 1'b1;
    bus.in_cdb_lsb_tag = tag;
    bus.in_cdb_lsb_val = val;
  endtask

  task automatic push(input logic [5:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag,
                      input int c);
    exp_t e;
    e.op = op; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.pc = pc; e.tag = tag; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_valid"}, 32'(bus.out_alu_valid), 32'd0);
    chk({pfx, "_full"},  32'(bus.out_full), 32'd0);
    chk({pfx, "_op"},    32'(bus.out_alu_op), 32'd0);
    chk({pfx, "_rs1"},   bus.out_alu_rs1, 32'd0);
    chk({pfx, "_rs2"},   bus.out_alu_rs2, 32'd0);
    chk({pfx, "_imm"},   bus.out_alu_imm, 32'd0);
    chk({pfx, "_pc"},    bus.out_alu_pc, 32'd0);
    chk({pfx, "_tag"},   32'(bus.out_alu_tag), 32'd0);
  endtask

  initial begin
    int c;
    bus.in_dsp_valid = 1'b0; bus.in_dsp_op = '0; bus.in_dsp_vj = '0; bus.in_dsp_vk = '0;
    bus.in_dsp_qj = '0; bus.in_dsp_qk = '0; bus.in_dsp_qj_vld = 1'b0; bus.in_dsp_qk_vld = 1'b0;
    bus.in_dsp_imm = '0; bus.in_dsp_pc = '0; bus.in_dsp_tag = '0;
    bus.in_cdb_alu_vld = 1'b0; bus.in_cdb_alu_tag = '0; bus.in_cdb_alu_val = '0;
    bus.in_cdb_lsb_vld = 1'b0; bus.in_cdb_lsb_tag = '0; bus.in_cdb_lsb_val = '0;
    rst = 1'b0;
    rdy = 1'b1;
    tick();
    tick();
    chk_reset_outputs("reset");
    rst = 1'b1;

    // Ready op issues one cycle after dispatch, then valid falls.
    dsp(OP_ADDI, 32'd5, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd7, 32'h100, 4'd3);
    push(OP_ADDI, 32'd5, 32'd0, 32'd7, 32'h100, 4'd3, cyc + 2);
    tick(); tick(); tick();
    chk("valid_after_single", 32'(bus.out_alu_valid), 32'd0);

    // Pending rs1 woken by the ALU CDB.
    dsp(OP_ADD, 32'd0, 32'd1, 1'b1, 4'd2, 1'b0, 4'd0, 32'd0, 32'h104, 4'd4);
    tick(); tick(); tick();
    cdb_alu(4'd2, 32'd9);
    push(OP_ADD, 32'd9, 32'd1, 32'd0, 32'h104, 4'd4, cyc + 2);
    tick(); tick(); tick();

    // Fill all entries with pending ops.
    for (int i = 0; i < 8; i++) begin
      dsp(OP_SUB, 32'd0, 32'h100 + 32'(i), 1'b1, (i == 0) ? 4'd12 : 4'd13,
          (i >= 1 && i <= 3), 4'd14, 32'(i), 32'h200 + 32'(4 * i), 4'(i));
      tick();
      if (i == 6) chk("full_at_7", 32'(bus.out_full), 32'd0);
    end
    chk("full_at_8", 32'(bus.out_full), 32'd1);
    dsp(OP_SUB, 32'd99, 32'd0, 1'b1, 4'd12, 1'b0, 4'd0, 32'd0, 32'h300, 4'd15);
    tick();
    chk("full_after_drop", 32'(bus.out_full), 32'd1);
    cdb_alu(4'd12, 32'h55);
    push(OP_SUB, 32'h55, 32'h100, 32'd0, 32'h200, 4'd0, cyc + 2);
    tick();
    chk("full_during_wake", 32'(bus.out_full), 32'd1);
    tick();
    chk("full_after_issue", 32'(bus.out_full), 32'd0);
    // Both CDBs hit entries 1..3; a new ready op reuses entry 0 and goes first.
    cdb_alu(4'd14, 32'h22);
    cdb_lsb(4'd13, 32'h77);
    dsp(OP_ADDI, 32'hA, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd1, 32'h400, 4'd9);
    c = cyc;
    push(OP_ADDI, 32'hA, 32'd0, 32'd1, 32'h400, 4'd9, c + 2);
    for (int i = 1; i < 8; i++)
      push(OP_SUB, 32'h77, (i <= 3) ? 32'h22 : 32'h100 + 32'(i), 32'(i),
           32'h200 + 32'(4 * i), 4'(i), c + 2 + i);
    for (int i = 0; i < 10; i++) tick();
    chk("full_drained", 32'(bus.out_full), 32'd0);

    // Flush with busy entries and a same-cycle ready dispatch.
    for (int i = 0; i < 3; i++) begin
      dsp(OP_ADD, 32'd0, 32'(i), 1'b1, 4'd1, 1'b0, 4'd0, 32'd0, 32'h500 + 32'(4 * i), 4'(i));
      tick();
    end
    in_clear = 1'b1;
    dsp(OP_ADDI, 32'd1, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 32'h510, 4'd5);
    tick();
    chk("full_after_clear", 32'(bus.out_full), 32'd0);
    chk("valid_after_clear", 32'(bus.out_alu_valid), 32'd0);
    cdb_alu(4'd1, 32'h33);
    tick(); tick(); tick();

    // rdy low drops dispatch and freezes a ready entry.
    rdy = 1'b0;
    dsp(OP_ADDI, 32'd2, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 32'h600, 4'd6);
    tick();
    rdy = 1'b1;
    tick(); tick();
    dsp(OP_ADDI, 32'd3, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd2, 32'h604, 4'd7);
    push(OP_ADDI, 32'd3, 32'd0, 32'd2, 32'h604, 4'd7, cyc + 4);
    tick();
    rdy = 1'b0;
    tick(); tick();
    rdy = 1'b1;
    tick(); tick();

    // Same-cycle CDB hit during dispatch.
    dsp(OP_ADD, 32'd0, 32'd4, 1'b1, 4'd5, 1'b0, 4'd0, 32'd0, 32'h700, 4'd8);
    cdb_lsb(4'd5, 32'h10);
`ifdef ALU_RS_CDB_BYPASS_EN
    push(OP_ADD, 32'h10, 32'd4, 32'd0, 32'h700, 4'd8, cyc + 2);
`endif
    tick(); tick(); tick();
    cdb_alu(4'd5, 32'h20);
`ifndef ALU_RS_CDB_BYPASS_EN
    push(OP_ADD, 32'h20, 32'd4, 32'd0, 32'h700, 4'd8, cyc + 2);
`endif
    tick(); tick(); tick();

    // Mid-operation reset discards a pending entry.
    dsp(OP_ADD, 32'd0, 32'd0, 1'b1, 4'd6, 1'b0, 4'd0, 32'd0, 32'h800, 4'd10);
    tick();
    rst = 1'b0;
    tick();
    chk_reset_outputs("midreset");
    rst = 1'b1;
    cdb_alu(4'd6, 32'd1);
    tick(); tick(); tick();

    tick(); tick();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
